iter_divider: RTL and testbench
===============================

Name: iter_divider

Overview:
- Multi-cycle restoring divider that responds to the EX-stage divider request interface.
- It is the slave end of the dividend/divisor stream pair and the source of the result stream.
- It replaces the vendor divider IP; one instance is built with SIGNED=1 for div.w/mod.w and one with SIGNED=0 for div.wu/mod.wu.
- Result packing is {quotient, remainder}: quotient in [63:32], remainder in [31:0].

Parameters:
- SIGNED, 1, 1 = two's-complement operands and results; 0 = unsigned.
- DW, 32, operand width; result width is 2*DW.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset: synchronous, active-low.
- s_axis_dividend_tdata  in  DW  dividend.
- s_axis_dividend_tvalid  in  1  dividend valid.
- s_axis_dividend_tready  out  1  dividend ready.
- s_axis_divisor_tdata  in  DW  divisor.
- s_axis_divisor_tvalid  in  1  divisor valid.
- s_axis_divisor_tready  out  1  divisor ready.
- m_axis_dout_tdata  out  2*DW  {quotient, remainder}.
- m_axis_dout_tvalid  out  1  result valid; one-cycle pulse, no backpressure.

Behaviour:
- Reset (resetn=0 at posedge):
  - state=IDLE; both treadys=1 in the following cycle.
  - m_axis_dout_tvalid=0, m_axis_dout_tdata=0.
  - Reset mid-operation aborts the operation; no result pulse is produced.
- FSM states: IDLE, CALC, DONE.
- Readiness: both treadys equal 1 only in IDLE, 0 in CALC and DONE.
- IDLE:
  - Accept when dividend_tvalid & divisor_tvalid (both treadys are high in IDLE).
  - A single valid without its partner is not accepted: nothing is captured and the state is held.
  - On accept:
    - capture |dividend| and |divisor| (magnitudes only when SIGNED=1);
    - record q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend);
    - clear the partial remainder; load cnt=0; go to CALC.
- CALC, one restoring step per cycle:
  - shift {rem, quo} left by 1;
  - trial = rem - divisor;
  - if trial is non-negative, rem=trial and the quotient LSB=1.
  - After DW steps (cnt reaches DW-1), go to DONE.
- DONE:
  - Apply sign correction: quotient negated if q_neg, remainder negated if r_neg.
  - Register the result into m_axis_dout_tdata and assert tvalid for exactly this one cycle, then go to IDLE.
- Latency: handshake at edge E; tvalid is high during the cycle after edge E+DW+1, i.e. DW+2 cycles from the accept edge (34 cycles for DW=32). The next accept is possible in the cycle after DONE.
- m_axis_dout_tdata holds its value after the pulse until the next DONE; the consumer reads it late.
- Divide by zero (defined, no trap): magnitude quotient = all ones, magnitude remainder = |dividend|, then normal sign correction.
  - Unsigned: q=0xFFFFFFFF, r=dividend.
  - Signed 7/0: q=0xFFFFFFFF, r=7. Signed -7/0: q=1, r=-7.
- Overflow 0x80000000 / -1 (SIGNED=1): q=0x80000000, r=0. The magnitude path needs no extra bit because |0x80000000| fits in DW unsigned.
- Inputs are ignored outside IDLE; tdata changes during CALC do not affect the result.

Optional Feature:
- Macro: ITER_DIVIDER_EARLY_EXIT_EN.
- Defined: in IDLE on accept, if |divisor| > |dividend| (magnitude compare; divisor ≠ 0 implied), skip CALC and go directly to DONE with magnitude quotient = 0 and remainder = |dividend|. Latency for that case is 2 cycles. All other cases are unchanged.
- Undefined: every operation takes the full DW+2 latency.
- Results are bit-identical in both builds.

Decomposition:
- Package div_pkg:
  - state enum {IDLE, CALC, DONE};
  - constant DIV_DW=32;
  - DIV_CNT_W = clog2(DIV_DW);
  - function abs_val(value, signed_flag).
- One natural sub-module, div_step: combinational single restoring step. Inputs are rem, quo, divisor; outputs are next rem and next quo. It is instantiated once inside the FSM datapath.

Test Plan:
- SIGNED=0, dividend=100, divisor=7, both tvalids high for 1 cycle -> tvalid pulse 34 cycles after the accept edge, tdata={14, 2}; treadys low throughout.
- SIGNED=1, -100 / 7 -> {0xFFFFFFF2, 0xFFFFFFFE}; 100 / -7 -> {0xFFFFFFF2, 2}; 0x80000000 / 0xFFFFFFFF -> {0x80000000, 0}.
- Divide by zero:
  - SIGNED=0, 5/0 -> {0xFFFFFFFF, 5};
  - SIGNED=1, -7/0 -> {1, 0xFFFFFFF9}.
- Handshake:
  - dividend_tvalid=1 with divisor_tvalid=0 for 5 cycles, then both high -> no accept until both are high; latency counts from the joint accept.
  - Operand tdata changed during CALC -> result unaffected.
- Reset during CALC (cycle 10) -> no tvalid pulse; treadys=1 and tdata=0 the cycle after reset. A new 9/3 op then returns {3, 0}.
- ITER_DIVIDER_EARLY_EXIT_EN defined, 3/10 -> {0, 3} with tvalid at 2-cycle latency; 20/3 -> {6, 2} at 34-cycle latency. Back-to-back ops issued the cycle after each pulse are all correct.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and helpers for the iterative restoring divider.
package div_pkg;

  localparam int DIV_DW    = 32;
  localparam int DIV_CNT_W = $clog2(DIV_DW);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // Two's-complement magnitude. The most negative value maps onto itself,
  // which is the correct unsigned magnitude.
  function automatic logic [DIV_DW-1:0] abs_val(input logic [DIV_DW-1:0] value,
                                                input logic              signed_flag);
    return (signed_flag && value[DIV_DW-1]) ? (~value + DIV_DW'(1)) : value;
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on the {rem, quo} pair.
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] i_rem,
  input  logic [DW-1:0] i_quo,
  input  logic [DW-1:0] i_dvs,
  output logic [DW-1:0] o_rem,
  output logic [DW-1:0] o_quo
);

  logic [DW:0] w_sh;
  logic        w_ok;

  // The shifted remainder needs one extra bit, but whenever the trial
  // subtraction succeeds its true difference fits in DW bits.
  assign w_sh  = {i_rem, i_quo[DW-1]};
  assign w_ok  = (w_sh >= {1'b0, i_dvs});
  assign o_rem = w_ok ? (w_sh[DW-1:0] - i_dvs) : w_sh[DW-1:0];
  assign o_quo = {i_quo[DW-2:0], w_ok};

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle restoring divider, result {quotient, remainder}.
// Optional ITER_DIVIDER_EARLY_EXIT_EN: skip iteration when |divisor| > |dividend|.
module iter_divider
  import div_pkg::*;
#(
  parameter int SIGNED = 1,
  parameter int DW     = DIV_DW
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [DW-1:0]   s_axis_dividend_tdata,
  input  logic            s_axis_dividend_tvalid,
  output logic            s_axis_dividend_tready,
  input  logic [DW-1:0]   s_axis_divisor_tdata,
  input  logic            s_axis_divisor_tvalid,
  output logic            s_axis_divisor_tready,
  output logic [2*DW-1:0] m_axis_dout_tdata,
  output logic            m_axis_dout_tvalid
);

  localparam logic SGN = (SIGNED != 0);

  div_state_e           r_state;
  logic [DW-1:0]        r_rem;
  logic [DW-1:0]        r_quo;
  logic [DW-1:0]        r_dvs;
  logic [DIV_CNT_W-1:0] r_cnt;
  logic                 r_q_neg;
  logic                 r_r_neg;
  logic [2*DW-1:0]      r_dout;
  logic                 r_dout_vld;

  logic [DW-1:0]        w_a_mag;
  logic [DW-1:0]        w_b_mag;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic                 w_accept;
  logic [DW-1:0]        w_rem_nxt;
  logic [DW-1:0]        w_quo_nxt;
  logic [DW-1:0]        w_q_fix;
  logic [DW-1:0]        w_r_fix;

  assign w_a_mag  = abs_val(s_axis_dividend_tdata, SGN);
  assign w_b_mag  = abs_val(s_axis_divisor_tdata, SGN);
  assign w_a_neg  = SGN & s_axis_dividend_tdata[DW-1];
  assign w_b_neg  = SGN & s_axis_divisor_tdata[DW-1];
  assign w_accept = (r_state == IDLE) & s_axis_dividend_tvalid & s_axis_divisor_tvalid;

  assign s_axis_dividend_tready = (r_state == IDLE);
  assign s_axis_divisor_tready  = (r_state == IDLE);
  assign m_axis_dout_tdata      = r_dout;
  assign m_axis_dout_tvalid     = r_dout_vld;

  div_step #(.DW(DW)) u_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_rem_nxt),
    .o_quo (w_quo_nxt)
  );

  // Divide-by-zero falls out of the datapath: every trial succeeds, so the
  // magnitude quotient becomes all ones and the remainder the dividend.
  assign w_q_fix = r_q_neg ? (~r_quo + DW'(1)) : r_quo;
  assign w_r_fix = r_r_neg ? (~r_rem + DW'(1)) : r_rem;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvs      <= '0;
      r_cnt      <= '0;
      r_q_neg    <= 1'b0;
      r_r_neg    <= 1'b0;
      r_dout     <= '0;
      r_dout_vld <= 1'b0;
    end else begin
      r_dout_vld <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_rem   <= '0;
            r_quo   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_cnt   <= '0;
            r_q_neg <= w_a_neg ^ w_b_neg;
            r_r_neg <= w_a_neg;
            r_state <= CALC;
`ifdef ITER_DIVIDER_EARLY_EXIT_EN
            if (w_b_mag > w_a_mag) begin
              r_rem   <= w_a_mag;
              r_quo   <= '0;
              r_state <= DONE;
            end
`endif
          end
        end
        CALC: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + DIV_CNT_W'(1);
          if (r_cnt == DIV_CNT_W'(DW - 1)) r_state <= DONE;
        end
        DONE: begin
          r_dout     <= {w_q_fix, w_r_fix};
          r_dout_vld <= 1'b1;
          r_state    <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench: one unsigned and one signed divider against an arithmetic model.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] ua, ub, sa, sb;
  logic        uav, ubv, sav, sbv;
  logic        uar, ubr, sar, sbr;
  logic [63:0] ud, sd;
  logic        uv, sv;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  iter_divider #(.SIGNED(0), .DW(32)) u_udiv (
    .clk(clk), .resetn(resetn),
    .s_axis_dividend_tdata(ua), .s_axis_dividend_tvalid(uav), .s_axis_dividend_tready(uar),
    .s_axis_divisor_tdata(ub), .s_axis_divisor_tvalid(ubv), .s_axis_divisor_tready(ubr),
    .m_axis_dout_tdata(ud), .m_axis_dout_tvalid(uv)
  );

  iter_divider #(.SIGNED(1), .DW(32)) u_sdiv (
    .clk(clk), .resetn(resetn),
    .s_axis_dividend_tdata(sa), .s_axis_dividend_tvalid(sav), .s_axis_dividend_tready(sar),
    .s_axis_divisor_tdata(sb), .s_axis_divisor_tvalid(sbv), .s_axis_divisor_tready(sbr),
    .m_axis_dout_tdata(sd), .m_axis_dout_tvalid(sv)
  );

  // Reference: truncating division, remainder takes the dividend's sign;
  // x/0 yields magnitude quotient all ones and remainder = dividend.
  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    longint na, nb;
    if (!sgn) begin
      if (b == 0) begin q = 32'hFFFF_FFFF; r = a; end
      else begin q = a / b; r = a % b; end
    end else begin
      na = longint'($signed(a));
      nb = longint'($signed(b));
      if (nb == 0) begin q = (na < 0) ? 32'd1 : 32'hFFFF_FFFF; r = a; end
      else begin q = 32'(na / nb); r = 32'(na % nb); end
    end
    return {q, r};
  endfunction

  function automatic int exp_lat(input bit sgn, input logic [31:0] a, input logic [31:0] b);
`ifdef ITER_DIVIDER_EARLY_EXIT_EN
    longint ma, mb;
    ma = sgn ? longint'($signed(a)) : longint'(a);
    mb = sgn ? longint'($signed(b)) : longint'(b);
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
    if (mb > ma) return 2;
`endif
    return 34;
  endfunction

  function automatic logic f_tv(input bit sgn);
    return sgn ? sv : uv;
  endfunction
  function automatic logic [63:0] f_td(input bit sgn);
    return sgn ? sd : ud;
  endfunction
  function automatic logic f_rdy_any(input bit sgn);
    return sgn ? (sar | sbr) : (uar | ubr);
  endfunction
  function automatic logic f_rdy_all(input bit sgn);
    return sgn ? (sar & sbr) : (uar & ubr);
  endfunction

  task automatic drive(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input logic av, input logic bv);
    if (sgn) begin sa = a; sb = b; sav = av; sbv = bv; end
    else     begin ua = a; ub = b; uav = av; ubv = bv; end
  endtask

  // Issues one op at the current negedge; lat counts cycles from the accept
  // edge to the pulse (DW+2 = 34 for a full op), -1 on timeout.
  task automatic do_op(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                       input bit scramble, output logic [63:0] got, output int lat,
                       output bit rdy_bad);
    drive(sgn, a, b, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    drive(sgn, a, b, 1'b0, 1'b0);
    lat = -1; rdy_bad = 1'b0; got = 'x;
    for (int n = 1; n <= 100; n++) begin
      if (f_rdy_any(sgn)) rdy_bad = 1'b1;
      if (scramble) drive(sgn, $urandom, $urandom, 1'b0, 1'b0);
      @(posedge clk); @(negedge clk);
      if (f_tv(sgn)) begin lat = n + 1; got = f_td(sgn); break; end
    end
  endtask

  task automatic check_op(input string name, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input bit scramble);
    logic [63:0] got, exp;
    int lat, el;
    bit rb;
    exp = model(sgn, a, b);
    el  = exp_lat(sgn, a, b);
    do_op(sgn, a, b, scramble, got, lat, rb);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s data a=%h b=%h got=%h exp=%h", name, a, b, got, exp);
    end
    total++;
    if (lat !== el) begin
      bad++;
      $display("FAIL %s latency got=%0d exp=%0d", name, lat, el);
    end
    total++;
    if (rb !== 1'b0) begin
      bad++;
      $display("FAIL %s tready high while busy got=%0d exp=0", name, rb);
    end
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    drive(1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int s = 0; s < 2; s++) begin
      total++;
      if ({f_rdy_all(s[0]), f_tv(s[0]), f_td(s[0])} !== {1'b1, 1'b0, 64'd0}) begin
        bad++;
        $display("FAIL reset_state sgn=%0d rdy=%b tv=%b td=%h exp rdy=1 tv=0 td=0",
                 s, f_rdy_all(s[0]), f_tv(s[0]), f_td(s[0]));
      end
    end
  endtask

  task automatic test_unsigned;
    logic [63:0] held;
    check_op("u_100_7", 1'b0, 32'd100, 32'd7, 1'b0);
    held = ud;
    @(posedge clk); @(negedge clk);
    total++;
    if (uv !== 1'b0 || ud !== held) begin
      bad++;
      $display("FAIL u_hold tv=%b td=%h exp tv=0 td=%h", uv, ud, held);
    end
    check_op("u_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 1'b0);
    check_op("u_max_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check_op("u_big_div", 1'b0, 32'h8000_0005, 32'h8000_0001, 1'b0);
    check_op("u_3_10", 1'b0, 32'd3, 32'd10, 1'b0);
  endtask

  task automatic test_signed;
    check_op("s_m100_7", 1'b1, -32'sd100, 32'd7, 1'b0);
    check_op("s_100_m7", 1'b1, 32'd100, -32'sd7, 1'b0);
    check_op("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check_op("s_m9_m4", 1'b1, -32'sd9, -32'sd4, 1'b0);
    check_op("s_3_10", 1'b1, 32'd3, 32'd10, 1'b0);
    check_op("s_20_3", 1'b1, 32'd20, 32'd3, 1'b0);
  endtask

  task automatic test_div_zero;
    check_op("u_5_0", 1'b0, 32'd5, 32'd0, 1'b0);
    check_op("s_m7_0", 1'b1, -32'sd7, 32'd0, 1'b0);
    check_op("s_7_0", 1'b1, 32'd7, 32'd0, 1'b0);
  endtask

  task automatic test_handshake;
    int errs = 0;
    drive(1'b0, 32'd1234, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (f_rdy_all(1'b0) !== 1'b1 || uv !== 1'b0) errs++;
    end
    total++;
    if (errs != 0) begin
      bad++;
      $display("FAIL single_valid_held errs=%0d exp=0", errs);
    end
    check_op("u_joint_accept", 1'b0, 32'd50, 32'd6, 1'b0);
    check_op("u_scramble", 1'b0, 32'd987654, 32'd321, 1'b1);
    check_op("s_scramble", 1'b1, -32'sd987654, 32'd321, 1'b1);
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    drive(1'b0, 32'd1000, 32'd3, 1'b1, 1'b1);
    @(posedge clk); @(negedge clk);
    drive(1'b0, 32'd1000, 32'd3, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    resetn = 1'b0;
    @(posedge clk); @(negedge clk);
    resetn = 1'b1;
    total++;
    if ({uar, ubr, uv, ud} !== {1'b1, 1'b1, 1'b0, 64'd0}) begin
      bad++;
      $display("FAIL reset_mid_state rdy=%b%b tv=%b td=%h exp rdy=11 tv=0 td=0", uar, ubr, uv, ud);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (uv) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL reset_mid_pulse got=%0d exp=0", pulses);
    end
    check_op("u_9_3_after_rst", 1'b0, 32'd9, 32'd3, 1'b0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 4))
      0: return 32'($urandom_range(0, 20));
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_back_to_back;
    for (int i = 0; i < 30; i++) begin
      check_op($sformatf("b2b_%0d", i), 1'($urandom_range(0, 1)), pick_operand(),
               pick_operand(), 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_handshake();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
